// File: rtl/tomasulo_pkg.sv
// Shared widths, tag/address types and helpers for the register file
// and the register-status table.
package tomasulo_pkg;

  localparam int DATA_W        = 16;
  localparam int TAG_W         = 3;
  localparam int NUM_ARCH_REGS = 7;

  typedef logic [2:0]       reg_addr_t;
  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t      TAG_NONE = '0;
  localparam reg_addr_t REG_ZERO = 3'd0;

  function automatic logic [2:0] popcount7(input logic [NUM_ARCH_REGS-1:0] bits);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      cnt = cnt + 3'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_status_entry.sv
// One architectural register: its value plus the Qi tag of the reservation
// station that will produce it (TAG_NONE when the value is current).
module reg_status_entry
  import tomasulo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_hit,
  input  tag_t              issue_tag,
  input  logic              load_hit,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cdb_valid,
  input  tag_t              cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] value,
  output tag_t              tag,
  output logic              busy,
  output logic              busy_next
);

  logic [DATA_W-1:0] value_reg, value_next;
  tag_t              tag_reg, tag_next;
  logic              cdb_hit;

  // A register only accepts a broadcast from the producer it is currently waiting on.
  assign cdb_hit = cdb_valid && (cdb_tag != TAG_NONE) && (tag_reg == cdb_tag);

  always_comb begin
    value_next = value_reg;
    tag_next   = tag_reg;
    if (cdb_hit) begin
      value_next = cdb_data;
      tag_next   = TAG_NONE;
    end else if (load_hit && (tag_reg == TAG_NONE)) begin
      value_next = load_data;
    end
    // A new rename always wins over the clear from a retiring producer.
    if (issue_hit) begin
      tag_next = issue_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_reg <= '0;
      tag_reg   <= TAG_NONE;
    end else begin
      value_reg <= value_next;
      tag_reg   <= tag_next;
    end
  end

  assign value     = value_reg;
  assign tag       = tag_reg;
  assign busy      = (tag_reg != TAG_NONE);
  assign busy_next = (tag_next != TAG_NONE);

endmodule

// File: rtl/reg_status_file.sv
// Architectural registers R1..R7 with their Tomasulo status tags: rename on
// issue, retire from the CDB, direct loads, and operand tag lookups.
module reg_status_file
  import tomasulo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  reg_addr_t         issue_dest,
  input  tag_t              issue_tag,
  input  logic              cdb_valid,
  input  tag_t              cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              load_valid,
  input  reg_addr_t         load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  reg_addr_t         src_a_addr,
  input  reg_addr_t         src_b_addr,
  output tag_t              src_a_tag,
  output tag_t              src_b_tag,
  output logic              src_a_busy,
  output logic              src_b_busy,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7,
  output logic [NUM_ARCH_REGS-1:0] busy_vec,
  output logic [2:0]        busy_count
);

  logic [DATA_W-1:0]        value_arr [NUM_ARCH_REGS];
  tag_t                     tag_arr   [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] busy_next_vec;
  logic [NUM_ARCH_REGS-1:0] issue_hit_vec;
  logic [NUM_ARCH_REGS-1:0] load_hit_vec;
  logic [2:0]               busy_count_reg;

  generate
    for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_entry
      // Entry gi holds architectural register gi+1; address 0 never decodes.
      assign issue_hit_vec[gi] = issue_valid && (issue_tag != TAG_NONE) &&
                                 (issue_dest == reg_addr_t'(gi + 1));
      assign load_hit_vec[gi]  = load_valid && !issue_hit_vec[gi] &&
                                 (load_addr == reg_addr_t'(gi + 1));

      reg_status_entry u_entry (
        .clock     (clock),
        .reset     (reset),
        .issue_hit (issue_hit_vec[gi]),
        .issue_tag (issue_tag),
        .load_hit  (load_hit_vec[gi]),
        .load_data (load_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .value     (value_arr[gi]),
        .tag       (tag_arr[gi]),
        .busy      (busy_vec[gi]),
        .busy_next (busy_next_vec[gi])
      );
    end
  endgenerate

  // Counted from next-state busy bits so it lines up with busy_vec each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_count_reg <= 3'd0;
    end else begin
      busy_count_reg <= popcount7(busy_next_vec);
    end
  end

  // Lookups see registered state only; stations snoop the CDB on their own.
  always_comb begin
    src_a_tag = TAG_NONE;
    src_b_tag = TAG_NONE;
    if (src_a_addr != REG_ZERO) begin
      src_a_tag = tag_arr[src_a_addr - 3'd1];
    end
    if (src_b_addr != REG_ZERO) begin
      src_b_tag = tag_arr[src_b_addr - 3'd1];
    end
  end

  assign src_a_busy = (src_a_tag != TAG_NONE);
  assign src_b_busy = (src_b_tag != TAG_NONE);
  assign busy_count = busy_count_reg;

  assign R1 = value_arr[0];
  assign R2 = value_arr[1];
  assign R3 = value_arr[2];
  assign R4 = value_arr[3];
  assign R5 = value_arr[4];
  assign R6 = value_arr[5];
  assign R7 = value_arr[6];

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: load, rename/retire, WAW, same-cycle
// issue+CDB, multi-match retire, load blocking and asynchronous reset.
module tb_reg_status_file;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        load_valid;
  logic [2:0]  load_addr;
  logic [15:0] load_data;
  logic [2:0]  src_a_addr, src_b_addr;
  logic [2:0]  src_a_tag, src_b_tag;
  logic        src_a_busy, src_b_busy;
  logic [15:0] R1, R2, R3, R4, R5, R6, R7;
  logic [6:0]  busy_vec;
  logic [2:0]  busy_count;

  int checks = 0;
  int errors = 0;

  reg_status_file dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .src_a_addr  (src_a_addr),
    .src_b_addr  (src_b_addr),
    .src_a_tag   (src_a_tag),
    .src_b_tag   (src_b_tag),
    .src_a_busy  (src_a_busy),
    .src_b_busy  (src_b_busy),
    .R1          (R1),
    .R2          (R2),
    .R3          (R3),
    .R4          (R4),
    .R5          (R5),
    .R6          (R6),
    .R7          (R7),
    .busy_vec    (busy_vec),
    .busy_count  (busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_dest = 3'd0; issue_tag = 3'd0;
    cdb_valid   = 1'b0; cdb_tag    = 3'd0; cdb_data  = 16'h0;
    load_valid  = 1'b0; load_addr  = 3'd0; load_data = 16'h0;
  endtask

  // Apply whatever is on the inputs for one edge, then return to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset_initial();
    reset = 1'b1;
    idle_inputs();
    src_a_addr = 3'd0; src_b_addr = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if ({R1, R2, R3, R4, R5, R6, R7} !== 112'h0) begin
      errors++; $display("FAIL reset_regs: got %h required 0", {R1, R2, R3, R4, R5, R6, R7});
    end
    checks++;
    if (busy_vec !== 7'b0 || busy_count !== 3'd0) begin
      errors++; $display("FAIL reset_busy: got vec=%b count=%0d required 0/0", busy_vec, busy_count);
    end
    $display("reset_initial: R=0 busy_vec=%b busy_count=%0d", busy_vec, busy_count);
  endtask

  task automatic test_load();
    load_valid = 1'b1; load_addr = 3'd3; load_data = 16'h00A5;
    tick();
    checks++;
    if (R3 !== 16'h00A5) begin
      errors++; $display("FAIL load_r3: got %h required 00a5", R3);
    end
    $display("load R3=00a5 -> R3=%h", R3);
    load_valid = 1'b1; load_addr = 3'd0; load_data = 16'hFFFF;
    tick();
    checks++;
    if ({R1, R2, R3, R4, R5, R6, R7} !== {16'h0, 16'h0, 16'h00A5, 16'h0, 16'h0, 16'h0, 16'h0}) begin
      errors++; $display("FAIL load_addr0: got %h required R3=00a5 only", {R1, R2, R3, R4, R5, R6, R7});
    end
    $display("load addr0 -> R3=%h others unchanged", R3);
  endtask

  task automatic test_rename_retire();
    issue_valid = 1'b1; issue_dest = 3'd5; issue_tag = 3'd2;
    tick();
    src_a_addr = 3'd5; src_b_addr = 3'd0;
    #1;
    checks++;
    if (busy_vec !== 7'b0010000 || busy_count !== 3'd1) begin
      errors++; $display("FAIL issue_busy: got vec=%b count=%0d required 0010000/1", busy_vec, busy_count);
    end
    checks++;
    if (src_a_tag !== 3'd2 || src_a_busy !== 1'b1) begin
      errors++; $display("FAIL lookup_a: got tag=%0d busy=%b required 2/1", src_a_tag, src_a_busy);
    end
    checks++;
    if (src_b_tag !== 3'd0 || src_b_busy !== 1'b0) begin
      errors++; $display("FAIL lookup_addr0: got tag=%0d busy=%b required 0/0", src_b_tag, src_b_busy);
    end
    $display("issue R5 tag2 -> busy_vec=%b tag_a=%0d", busy_vec, src_a_tag);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h1234;
    tick();
    checks++;
    if (R5 !== 16'h1234 || busy_vec !== 7'b0 || busy_count !== 3'd0 || src_a_busy !== 1'b0) begin
      errors++; $display("FAIL retire_r5: got R5=%h vec=%b count=%0d busy=%b required 1234/0/0/0",
                         R5, busy_vec, busy_count, src_a_busy);
    end
    $display("cdb tag2 1234 -> R5=%h busy_count=%0d", R5, busy_count);
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_dest = 3'd4; issue_tag = 3'd1;
    tick();
    issue_valid = 1'b1; issue_dest = 3'd4; issue_tag = 3'd3;
    tick();
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'hDEAD;
    tick();
    src_a_addr = 3'd4;
    #1;
    checks++;
    if (R4 !== 16'h0 || src_a_tag !== 3'd3 || busy_count !== 3'd1) begin
      errors++; $display("FAIL waw_stale_cdb: got R4=%h tag=%0d count=%0d required 0000/3/1",
                         R4, src_a_tag, busy_count);
    end
    $display("waw stale cdb tag1 -> R4=%h Q4=%0d", R4, src_a_tag);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'hBEEF;
    tick();
    checks++;
    if (R4 !== 16'hBEEF || src_a_tag !== 3'd0 || busy_count !== 3'd0) begin
      errors++; $display("FAIL waw_retire: got R4=%h tag=%0d count=%0d required beef/0/0",
                         R4, src_a_tag, busy_count);
    end
    $display("cdb tag3 beef -> R4=%h", R4);
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1; issue_dest = 3'd2; issue_tag = 3'd1;
    tick();
    issue_valid = 1'b1; issue_dest = 3'd2; issue_tag = 3'd4;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0007;
    tick();
    src_a_addr = 3'd2;
    #1;
    checks++;
    if (R2 !== 16'h0007 || src_a_tag !== 3'd4 || src_a_busy !== 1'b1 ||
        busy_vec !== 7'b0000010 || busy_count !== 3'd1) begin
      errors++; $display("FAIL same_cycle: got R2=%h tag=%0d vec=%b count=%0d required 0007/4/0000010/1",
                         R2, src_a_tag, busy_vec, busy_count);
    end
    $display("issue R2 tag4 + cdb tag1 0007 -> R2=%h Q2=%0d", R2, src_a_tag);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0070;
    tick();
    checks++;
    if (R2 !== 16'h0070 || busy_count !== 3'd0) begin
      errors++; $display("FAIL same_cycle_retire: got R2=%h count=%0d required 0070/0", R2, busy_count);
    end
    // Issue and CDB share a tag on an idle register: the new rename must survive.
    issue_valid = 1'b1; issue_dest = 3'd7; issue_tag = 3'd6;
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h5555;
    tick();
    src_a_addr = 3'd7;
    #1;
    checks++;
    if (R7 !== 16'h0 || src_a_tag !== 3'd6 || busy_count !== 3'd1) begin
      errors++; $display("FAIL issue_eq_cdb: got R7=%h tag=%0d count=%0d required 0000/6/1",
                         R7, src_a_tag, busy_count);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h6666;
    tick();
    checks++;
    if (R7 !== 16'h6666 || busy_vec !== 7'b0) begin
      errors++; $display("FAIL issue_eq_cdb_retire: got R7=%h vec=%b required 6666/0", R7, busy_vec);
    end
    $display("issue R7 tag6 with cdb tag6 -> later R7=%h", R7);
  endtask

  task automatic test_multi_match();
    issue_valid = 1'b1; issue_dest = 3'd1; issue_tag = 3'd5;
    tick();
    issue_valid = 1'b1; issue_dest = 3'd6; issue_tag = 3'd5;
    tick();
    load_valid = 1'b1; load_addr = 3'd1; load_data = 16'hFFFF;
    tick();
    checks++;
    if (R1 !== 16'h0 || busy_vec !== 7'b0100001 || busy_count !== 3'd2) begin
      errors++; $display("FAIL load_blocked_busy: got R1=%h vec=%b count=%0d required 0000/0100001/2",
                         R1, busy_vec, busy_count);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0042;
    tick();
    checks++;
    if (R1 !== 16'h0042 || R6 !== 16'h0042 || busy_count !== 3'd0 || busy_vec !== 7'b0) begin
      errors++; $display("FAIL multi_match: got R1=%h R6=%h count=%0d required 0042/0042/0",
                         R1, R6, busy_count);
    end
    $display("cdb tag5 0042 -> R1=%h R6=%h busy_count=%0d", R1, R6, busy_count);
    // Load and issue to the same register in one cycle: load dropped, rename kept.
    load_valid = 1'b1; load_addr = 3'd3; load_data = 16'h1111;
    issue_valid = 1'b1; issue_dest = 3'd3; issue_tag = 3'd2;
    tick();
    src_a_addr = 3'd3;
    #1;
    checks++;
    if (R3 !== 16'h00A5 || src_a_tag !== 3'd2) begin
      errors++; $display("FAIL load_vs_issue: got R3=%h tag=%0d required 00a5/2", R3, src_a_tag);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 16'h7777;
    tick();
    checks++;
    if (R3 !== 16'h00A5 || src_a_tag !== 3'd2 || busy_count !== 3'd1) begin
      errors++; $display("FAIL unmatched_cdb: got R3=%h tag=%0d count=%0d required 00a5/2/1",
                         R3, src_a_tag, busy_count);
    end
    $display("load+issue R3, unmatched cdb -> R3=%h Q3=%0d", R3, src_a_tag);
  endtask

  task automatic test_reset_midstream();
    load_valid = 1'b1; load_addr = 3'd2; load_data = 16'h9999;
    tick();
    src_a_addr = 3'd3; src_b_addr = 3'd2;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({R1, R2, R3, R4, R5, R6, R7} !== 112'h0) begin
      errors++; $display("FAIL async_reset_regs: got %h required 0", {R1, R2, R3, R4, R5, R6, R7});
    end
    checks++;
    if (busy_vec !== 7'b0 || busy_count !== 3'd0 || src_a_tag !== 3'd0 || src_b_tag !== 3'd0) begin
      errors++; $display("FAIL async_reset_status: got vec=%b count=%0d tag_a=%0d tag_b=%0d required 0",
                         busy_vec, busy_count, src_a_tag, src_b_tag);
    end
    $display("async reset mid-stream -> busy_vec=%b busy_count=%0d", busy_vec, busy_count);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset_initial();
    test_load();
    test_rename_retire();
    test_waw();
    test_same_cycle();
    test_multi_match();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file R1..R7 (16-bit) plus Tomasulo register-status table (Qi tag per register).
- Sits directly upstream of the register read mux: drives R1..R7 as flat outputs, which the mux selects from by RegAddr.
- Issue stage renames a destination register to a reservation-station tag.
- CDB broadcasts retire results into every register still waiting on that tag.

Parameters:
- DATA_W, 16, register data width; must match the read mux.
- TAG_W, 3, reservation-station tag width; tag value 0 means "no producer / value valid".

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- issue_valid  input  1  issue stage renames a destination this cycle
- issue_dest  input  3  destination register 1..7; 0 ignored
- issue_tag  input  TAG_W  producing RS tag; 0 illegal, issue ignored
- cdb_valid  input  1  common data bus broadcast valid
- cdb_tag  input  TAG_W  tag of broadcasting RS; 0 ignored
- cdb_data  input  DATA_W  result value
- load_valid  input  1  direct architectural write (preload/debug)
- load_addr  input  3  load target 1..7; 0 ignored
- load_data  input  DATA_W  load value
- src_a_addr, src_b_addr  input  3  operand lookup addresses
- src_a_tag, src_b_tag  output  TAG_W  current Qi of addressed register; 0 for address 0
- src_a_busy, src_b_busy  output  1  Qi != 0
- R1..R7  output  DATA_W each  register values, to read mux
- busy_vec  output  7  bit i-1 = Ri waiting on a tag
- busy_count  output  3  number of busy registers, 0..7

Behaviour:
- Reset (async, any time, including mid-operation): all Ri = 0; all Qi = 0; busy_vec = 0; busy_count = 0.
- Register 0 does not exist as storage. Address 0 writes, issues and loads are no-ops. Lookups at address 0 return tag 0, busy 0.
- All updates occur on the rising clock edge and are visible on outputs the next cycle. Single-cycle latency, no stalls.
- CDB retire:
  - If cdb_valid, cdb_tag != 0, and Qi == cdb_tag for register i: Ri <= cdb_data and Qi <= 0.
  - Applies to every matching register in parallel; several registers may share a tag if the same RS was reissued.
- Issue:
  - If issue_valid, issue_dest != 0, and issue_tag != 0: Q[issue_dest] <= issue_tag.
  - The value is unchanged, except as described under the same-cycle cases below.
  - Issue to an already-busy register overwrites the tag (WAW rename); the older producer's later broadcast no longer updates that register.
- Same cycle, issue and CDB on the same register whose old tag matches cdb_tag:
  - Ri <= cdb_data.
  - Qi <= issue_tag; the new tag wins and busy stays 1.
- Same cycle, issue_tag == cdb_tag on a not-yet-renamed register: the issue takes effect; that CDB does not clear the new tag.
- Load:
  - If load_valid, load_addr != 0, Q[load_addr] == 0, and no issue targets load_addr this cycle: R[load_addr] <= load_data.
  - Otherwise the load is dropped silently.
  - A load never changes tags.
- Value priority per register: CDB match > load. Tag priority: issue > CDB clear.
- Operand lookups are combinational from registered state only, with no CDB bypass; reservation stations snoop the CDB themselves.
- busy_count is registered, recomputed from next-state busy bits so that it is consistent with busy_vec every cycle.
- Tags are never validated against a live-RS list. A broadcast with no matching register has no effect.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W and TAG_W
  - TAG_NONE = 0
  - REG_ZERO = 3'd0
  - NUM_ARCH_REGS = 7
  - a register-address typedef and a tag typedef
- One natural sub-module, reg_status_entry, instantiated 7 times:
  - holds one value and one tag;
  - inputs: its own issue_hit, load_hit, and the CDB bus;
  - outputs: value, tag, busy.
- The top level does address decode, lookup muxing and popcount.

Test Plan:
- Reset: assert reset mid-stream after the registers are loaded -> immediately R1..R7 = 0, busy_vec = 0, busy_count = 0, src tags 0.
- Load then read: load R3 = 16'h00A5 -> next cycle R3 = 16'h00A5. Load to address 0 -> no output changes.
- Rename and retire:
  - issue dest 5, tag 2 -> busy_vec = 7'b0010000, src_a_addr = 5 gives tag 2, busy 1.
  - cdb tag 2, data 16'h1234 -> R5 = 16'h1234, busy 0, count 0.
- WAW rename: issue R4 tag 1, then issue R4 tag 3, then cdb tag 1 data 16'hDEAD -> R4 unchanged, Q4 = 3. Then cdb tag 3 data 16'hBEEF -> R4 = 16'hBEEF.
- Same-cycle issue and CDB: R2 busy on tag 1; in one cycle issue R2 tag 4 and cdb tag 1 data 16'h0007 -> R2 = 16'h0007, Q2 = 4, busy 1.
- Multi-match and load blocking:
  - R1 and R6 both tag 5, load R1 = 16'hFFFF -> dropped.
  - cdb tag 5 data 16'h0042 -> R1 = R6 = 16'h0042, busy_count drops by 2.
